// File: rtl/tinker_mem_arbiter.sv
// tinker_mem_arbiter: fetch/data arbiter onto one single-ported memory, with anti-starvation and ack timeout.
module tinker_mem_arbiter #(
   parameter int STARVE_LIMIT = 2,
   parameter int TIMEOUT      = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        f_req,
   input  logic [63:0] f_addr,
   output logic        f_gnt,
   output logic        f_valid,
   output logic [31:0] f_rdata,
   output logic        f_err,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [63:0] d_addr,
   input  logic [63:0] d_wdata,
   output logic        d_gnt,
   output logic        d_valid,
   output logic [63:0] d_rdata,
   output logic        d_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   input  logic [63:0] mem_rdata,
   input  logic        mem_ack
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam int BW = $clog2(TIMEOUT + 1);
   localparam logic [SW-1:0] S_LIM = SW'(STARVE_LIMIT);
   localparam logic [BW-1:0] B_LIM = BW'(TIMEOUT - 1);
   typedef enum logic [1:0] {IDLE, BUSY_F, BUSY_D} state_t;
   state_t state, state_n;
   logic [SW-1:0] starve_cnt, starve_n;
   logic [BW-1:0] busy_cnt, busy_n;
   logic f_gnt_n, f_valid_n, f_err_n, d_gnt_n, d_valid_n, d_err_n, mem_req_n, mem_we_n;
   logic [31:0] f_rdata_n;
   logic [63:0] d_rdata_n, mem_addr_n, mem_wdata_n;
   logic pick_f;
   assign pick_f = f_req && (!d_req || starve_cnt == S_LIM);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         starve_cnt <= '0;
         busy_cnt   <= '0;
         f_gnt      <= 1'b0;
         f_valid    <= 1'b0;
         f_err      <= 1'b0;
         f_rdata    <= '0;
         d_gnt      <= 1'b0;
         d_valid    <= 1'b0;
         d_err      <= 1'b0;
         d_rdata    <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         state      <= state_n;
         starve_cnt <= starve_n;
         busy_cnt   <= busy_n;
         f_gnt      <= f_gnt_n;
         f_valid    <= f_valid_n;
         f_err      <= f_err_n;
         f_rdata    <= f_rdata_n;
         d_gnt      <= d_gnt_n;
         d_valid    <= d_valid_n;
         d_err      <= d_err_n;
         d_rdata    <= d_rdata_n;
         mem_req    <= mem_req_n;
         mem_we     <= mem_we_n;
         mem_addr   <= mem_addr_n;
         mem_wdata  <= mem_wdata_n;
      end
   end
   always_comb begin
      state_n     = state;
      starve_n    = starve_cnt;
      busy_n      = busy_cnt;
      f_gnt_n     = 1'b0;
      f_valid_n   = 1'b0;
      f_err_n     = 1'b0;
      f_rdata_n   = f_rdata;
      d_gnt_n     = 1'b0;
      d_valid_n   = 1'b0;
      d_err_n     = 1'b0;
      d_rdata_n   = d_rdata;
      mem_req_n   = mem_req;
      mem_we_n    = mem_we;
      mem_addr_n  = mem_addr;
      mem_wdata_n = mem_wdata;
      if (state == IDLE) begin
         if (f_req || d_req) begin
            busy_n    = '0;
            mem_req_n = 1'b1;
            if (pick_f) begin
               state_n     = BUSY_F;
               f_gnt_n     = 1'b1;
               starve_n    = '0;
               mem_we_n    = 1'b0;
               mem_addr_n  = f_addr;
               mem_wdata_n = '0;
            end else begin
               state_n     = BUSY_D;
               d_gnt_n     = 1'b1;
               starve_n    = !f_req ? '0 : (starve_cnt == S_LIM) ? starve_cnt : starve_cnt + 1'b1;
               mem_we_n    = d_we;
               mem_addr_n  = d_addr;
               mem_wdata_n = d_wdata;
            end
         end
      end else if (mem_ack || busy_cnt == B_LIM) begin
         // an ack arriving on the timeout cycle still counts as a clean completion
         state_n   = IDLE;
         mem_req_n = 1'b0;
         if (state == BUSY_F) begin
            f_valid_n = 1'b1;
            f_err_n   = !mem_ack;
            f_rdata_n = mem_ack ? mem_rdata[31:0] : '0;
         end else begin
            d_valid_n = 1'b1;
            d_err_n   = !mem_ack;
            d_rdata_n = (mem_ack && !mem_we) ? mem_rdata : '0;
         end
      end else begin
         busy_n = busy_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_tinker_mem_arbiter.sv
// tb_tinker_mem_arbiter: directed checks of arbitration, latency, timeout and reset behaviour.
module tb_tinker_mem_arbiter;
   logic        clk, reset;
   logic        f_req, f_gnt, f_valid, f_err;
   logic [63:0] f_addr;
   logic [31:0] f_rdata;
   logic        d_req, d_we, d_gnt, d_valid, d_err;
   logic [63:0] d_addr, d_wdata, d_rdata;
   logic        mem_req, mem_we, mem_ack;
   logic [63:0] mem_addr, mem_wdata, mem_rdata;
   int compared = 0;
   int mismatched = 0;

   tinker_mem_arbiter #(.STARVE_LIMIT(2), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid), .f_rdata(f_rdata), .f_err(f_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [5:0] exp_f;
      exp_f = 6'b100100;
      reset = 1'b1;
      f_req = 0; f_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
      mem_ack = 0; mem_rdata = '0;
      #2 reset = 1'b0;
      #1;
      chk("rst_mem_req", mem_req, 0);
      chk("rst_gnts", {f_gnt, d_gnt, f_valid, d_valid, f_err, d_err}, 0);
      chk("rst_rdata", {f_rdata, d_rdata[31:0]}, 0);
      chk("rst_mem_addr", mem_addr, 0);
      tick();
      tick();
      reset = 1'b1;
      // fetch with one-cycle ack
      f_req = 1; f_addr = 64'h2000;
      tick();
      chk("f_gnt", f_gnt, 1);
      chk("f_mem_req", mem_req, 1);
      chk("f_mem_addr", mem_addr, 64'h2000);
      chk("f_mem_we", mem_we, 0);
      f_req = 0; mem_ack = 1; mem_rdata = 64'h11223344_AABBCCDD;
      tick();
      chk("f_valid", {f_valid, f_err, f_gnt, mem_req}, 4'b1000);
      chk("f_rdata", f_rdata, 32'hAABBCCDD);
      mem_ack = 0; mem_rdata = '0;
      tick();
      chk("f_valid_drop", {f_valid, f_err}, 0);
      chk("f_rdata_hold", f_rdata, 32'hAABBCCDD);
      // store
      d_req = 1; d_we = 1; d_addr = 64'h3000; d_wdata = 64'hDEADBEEF;
      tick();
      chk("st_gnt", {d_gnt, mem_req, mem_we}, 3'b111);
      chk("st_addr", mem_addr, 64'h3000);
      chk("st_wdata", mem_wdata, 64'hDEADBEEF);
      d_req = 0; mem_ack = 1; mem_rdata = 64'h5555;
      tick();
      chk("st_valid", {d_valid, d_err}, 2'b10);
      chk("st_rdata", d_rdata, 0);
      mem_ack = 0;
      // starvation limit: both held, immediate ack
      f_req = 1; d_req = 1; d_we = 0; mem_rdata = 64'h01234567_89ABCDEF;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("order_%0d", i), {f_gnt, d_gnt}, {exp_f[i], !exp_f[i]});
         mem_ack = 1;
         tick();
         mem_ack = 0;
         if (exp_f[i]) chk($sformatf("order_f_rdata_%0d", i), {f_valid, f_rdata}, {1'b1, 32'h89ABCDEF});
         else          chk($sformatf("order_d_rdata_%0d", i), {d_valid, d_rdata}, {1'b1, 64'h01234567_89ABCDEF});
      end
      f_req = 0; d_req = 0;
      tick();
      chk("idle_after_order", {mem_req, f_gnt, d_gnt}, 0);
      // load timeout
      d_req = 1; d_we = 0; d_addr = 64'h4000;
      tick();
      chk("to_gnt", d_gnt, 1);
      d_req = 0;
      repeat (15) tick();
      chk("to_pending", {d_valid, mem_req}, 2'b01);
      tick();
      chk("to_valid", {d_valid, d_err, mem_req}, 3'b110);
      chk("to_rdata", d_rdata, 0);
      mem_ack = 1; mem_rdata = 64'hFFFF;
      tick();
      mem_ack = 0;
      chk("late_ack", {d_valid, d_err, f_valid, mem_req}, 0);
      // ack on the timeout cycle
      f_req = 1; f_addr = 64'h2400;
      tick();
      chk("ta_gnt", f_gnt, 1);
      f_req = 0;
      repeat (15) tick();
      mem_ack = 1; mem_rdata = 64'hCAFEF00D_12345678;
      tick();
      mem_ack = 0;
      chk("ta_valid", {f_valid, f_err, mem_req}, 3'b100);
      chk("ta_rdata", f_rdata, 32'h12345678);
      // reset during BUSY_D
      d_req = 1; d_we = 1; d_addr = 64'h6000; d_wdata = 64'h77;
      tick();
      chk("rb_gnt", d_gnt, 1);
      d_req = 0; f_req = 1; f_addr = 64'h5000;
      tick();
      chk("rb_busy", {mem_req, f_gnt}, 2'b10);
      #2 reset = 1'b0;
      #1;
      chk("rb_async", {mem_req, mem_we, d_gnt, d_valid}, 0);
      chk("rb_addr", mem_addr, 0);
      tick();
      reset = 1'b1; mem_ack = 1;
      tick();
      mem_ack = 0;
      chk("rb_no_valid", {d_valid, f_valid}, 0);
      chk("rb_f_gnt", {f_gnt, mem_req}, 2'b11);
      chk("rb_f_addr", mem_addr, 64'h5000);
      f_req = 0; mem_ack = 1; mem_rdata = 64'h9;
      tick();
      mem_ack = 0;
      chk("rb_f_valid", {f_valid, f_err, f_rdata}, {2'b10, 32'h9});
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/tinker_mem_arbiter.md
TINKER_MEM_ARBITER -- requirements
Module: tinker_mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 2, max consecutive data grants while fetch waits.
REQ-002 Parameter TIMEOUT, default 16, max busy cycles awaiting mem_ack before error completion.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low; 0 clears all state immediately.
REQ-005 f_req  input  1  fetch read request, held until f_gnt.
REQ-006 f_addr  input  64  fetch byte address.
REQ-007 f_gnt  output  1  one-cycle pulse, fetch request accepted.
REQ-008 f_valid  output  1  one-cycle pulse, fetch completion.
REQ-009 f_rdata  output  32  instruction word, valid with f_valid.
REQ-010 f_err  output  1  timeout flag, valid with f_valid.
REQ-011 d_req  input  1  data request, held until d_gnt.
REQ-012 d_we  input  1  1 = store, 0 = load.
REQ-013 d_addr  input  64  data byte address.
REQ-014 d_wdata  input  64  store data.
REQ-015 d_gnt  output  1  one-cycle pulse, data request accepted.
REQ-016 d_valid  output  1  one-cycle pulse, data completion.
REQ-017 d_rdata  output  64  load data, valid with d_valid.
REQ-018 d_err  output  1  timeout flag, valid with d_valid.
REQ-019 mem_req  output  1  request to single-ported memory, held high until ack/timeout.
REQ-020 mem_we  output  1  memory write enable.
REQ-021 mem_addr  output  64  memory byte address.
REQ-022 mem_wdata  output  64  memory write data.
REQ-023 mem_rdata  input  64  memory read data, sampled with mem_ack.
REQ-024 mem_ack  input  1  memory completion, one cycle.

Function
REQ-025 States IDLE, BUSY_F, BUSY_D; all outputs registered.
REQ-026 IDLE: requests sampled at rising edge; none -> stay IDLE.
REQ-027 Arbitration: data wins over fetch, except both requesting and starve_cnt == STARVE_LIMIT -> fetch wins.
REQ-028 starve_cnt: +1 on data grant with f_req high; cleared on data grant with f_req low, on any fetch grant; saturates at STARVE_LIMIT.
REQ-029 On grant edge: latch addr (and we, wdata for data), enter BUSY_x; next cycle x_gnt=1 for exactly one cycle, mem_req=1.
REQ-030 Fetch: mem_we=0, mem_wdata=0; data: mem_we=d_we, mem_wdata=d_wdata latched; mem_addr/we/wdata stable throughout BUSY.
REQ-031 Requests sampled while BUSY are ignored; requester keeps req high until its gnt.
REQ-032 busy_cnt: 0 on BUSY entry, +1 each BUSY cycle without mem_ack.
REQ-033 mem_ack=1 in BUSY: next cycle x_valid=1, x_err=0, rdata = mem_rdata (fetch: bits 31:0; store: d_rdata=0); mem_req=0; -> IDLE.
REQ-034 busy_cnt reaches TIMEOUT-1 without ack: next cycle x_valid=1, x_err=1, rdata=0, mem_req=0, -> IDLE.
REQ-035 mem_ack on same edge as timeout: ack wins, err=0.
REQ-036 mem_ack while IDLE (late ack) ignored, no valid pulse.
REQ-037 Minimum latency: req in IDLE cycle 0 -> gnt cycle 1 -> ack cycle 1 -> valid cycle 2; next grant earliest cycle 3.
REQ-038 f_rdata/d_rdata hold last value between valid pulses; err cleared when valid low.

Reset
REQ-039 reset=0: state IDLE, starve_cnt=0, busy_cnt=0, all outputs 0, asynchronously.
REQ-040 Reset mid-transaction drops it: no valid pulse; subsequent mem_ack ignored.
REQ-041 First arbitration on first rising edge with reset=1.

Verification
REQ-042 f_req only, f_addr=0x2000, ack 1 cycle after mem_req with rdata=0x11223344_AABBCCDD -> f_gnt cycle 1, f_valid cycle 2, f_rdata=0xAABBCCDD, f_err=0.
REQ-043 d_req store, d_addr=0x3000, d_wdata=0xDEADBEEF -> mem_we=1, mem_addr=0x3000, mem_wdata=0xDEADBEEF; d_valid, d_rdata=0.
REQ-044 f_req and d_req held continuously, immediate ack -> grant order D,D,F,D,D,F (STARVE_LIMIT=2).
REQ-045 Load with mem_ack never asserted, TIMEOUT=16 -> d_valid=1, d_err=1, d_rdata=0 exactly 16 cycles after d_gnt; late ack ignored.
REQ-046 mem_ack on the timeout cycle -> valid with err=0, rdata=mem_rdata.
REQ-047 reset=0 during BUSY_D -> outputs 0 same cycle, no d_valid; after release, pending f_req granted normally.
